// File: rtl/apple_placer_if.sv
// Apple placement bundle: request/status toward the game FSM,
// random candidate stream in, occupancy memory read port out.
interface apple_placer_if;
    logic [3:0] rand_x;
    logic [3:0] rand_y;
    logic       place_req;
    logic       occ_rd_en;
    logic [3:0] occ_rd_x;
    logic [3:0] occ_rd_y;
    logic       occ_rd_data;
    logic [3:0] apple_x;
    logic [3:0] apple_y;
    logic       apple_valid;
    logic       place_busy;
    logic       place_done;
    logic       board_full;

    modport master (
        output rand_x, rand_y, place_req, occ_rd_data,
        input  occ_rd_en, occ_rd_x, occ_rd_y,
        input  apple_x, apple_y, apple_valid,
        input  place_busy, place_done, board_full
    );

    modport slave (
        input  rand_x, rand_y, place_req, occ_rd_data,
        output occ_rd_en, occ_rd_x, occ_rd_y,
        output apple_x, apple_y, apple_valid,
        output place_busy, place_done, board_full
    );
endinterface

// File: rtl/apple_placer.sv
// Apple placer: random candidates checked against snake occupancy,
// raster-scan fallback after MAX_TRIES misses, holds committed apple.
module apple_placer #(
    parameter int MAX_TRIES = 8,
    parameter int GRID_MIN  = 1,
    parameter int GRID_MAX  = 14
) (
    input  logic         clk,
    input  logic         reset_n,
    apple_placer_if.slave bus
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [3:0] GMIN = 4'(GRID_MIN);
    localparam logic [3:0] GMAX = 4'(GRID_MAX);

    typedef enum logic [2:0] {
        IDLE, RAND_RD, RAND_CHK, SCAN_RD, SCAN_CHK
    } state_t;

    state_t        state, state_n;
    logic [3:0]    cand_x, cand_x_n;
    logic [3:0]    cand_y, cand_y_n;
    logic [TW-1:0] tries, tries_n;
    logic [3:0]    apple_x_n, apple_y_n;
    logic          valid_n, busy_n, done_n, full_n;
    logic          in_range;

    assign in_range = (cand_x >= GMIN) && (cand_x <= GMAX) &&
                      (cand_y >= GMIN) && (cand_y <= GMAX);

    assign bus.occ_rd_x  = cand_x;
    assign bus.occ_rd_y  = cand_y;
    assign bus.occ_rd_en = (state == RAND_RD) || (state == SCAN_RD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cand_x          <= '0;
            cand_y          <= '0;
            tries           <= '0;
            bus.apple_x     <= '0;
            bus.apple_y     <= '0;
            bus.apple_valid <= 1'b0;
            bus.place_busy  <= 1'b0;
            bus.place_done  <= 1'b0;
            bus.board_full  <= 1'b0;
        end else begin
            state           <= state_n;
            cand_x          <= cand_x_n;
            cand_y          <= cand_y_n;
            tries           <= tries_n;
            bus.apple_x     <= apple_x_n;
            bus.apple_y     <= apple_y_n;
            bus.apple_valid <= valid_n;
            bus.place_busy  <= busy_n;
            bus.place_done  <= done_n;
            bus.board_full  <= full_n;
        end
    end

    always_comb begin
        state_n   = state;
        cand_x_n  = cand_x;
        cand_y_n  = cand_y;
        tries_n   = tries;
        apple_x_n = bus.apple_x;
        apple_y_n = bus.apple_y;
        valid_n   = bus.apple_valid;
        busy_n    = bus.place_busy;
        full_n    = bus.board_full;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.place_req) begin
                    cand_x_n = bus.rand_x;
                    cand_y_n = bus.rand_y;
                    tries_n  = '0;
                    valid_n  = 1'b0;
                    full_n   = 1'b0;
                    busy_n   = 1'b1;
                    state_n  = RAND_RD;
                end
            end
            RAND_RD: state_n = RAND_CHK;
            RAND_CHK: begin
                if (!bus.occ_rd_data && in_range) begin
                    apple_x_n = cand_x;
                    apple_y_n = cand_y;
                    valid_n   = 1'b1;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = IDLE;
                end else if (tries == TW'(MAX_TRIES - 1)) begin
                    cand_x_n = GMIN;
                    cand_y_n = GMIN;
                    state_n  = SCAN_RD;
                end else begin
                    tries_n  = tries + TW'(1);
                    cand_x_n = bus.rand_x;
                    cand_y_n = bus.rand_y;
                    state_n  = RAND_RD;
                end
            end
            SCAN_RD: state_n = SCAN_CHK;
            SCAN_CHK: begin
                if (!bus.occ_rd_data) begin
                    apple_x_n = cand_x;
                    apple_y_n = cand_y;
                    valid_n   = 1'b1;
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = IDLE;
                end else if (cand_x == GMAX && cand_y == GMAX) begin
                    full_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    // raster order: x fastest, wrap to next row
                    if (cand_x == GMAX) begin
                        cand_x_n = GMIN;
                        cand_y_n = cand_y + 4'd1;
                    end else begin
                        cand_x_n = cand_x + 4'd1;
                    end
                    state_n = SCAN_RD;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_apple_placer.sv
// Directed bench for apple_placer with a behavioural
// occupancy memory (1-cycle read latency).
module tb_apple_placer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    logic occ [16][16];

    apple_placer_if bus();

    apple_placer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        bus.occ_rd_data <= occ[bus.occ_rd_x][bus.occ_rd_y];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic v);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                occ[i][j] = v;
    endtask

    task automatic req();
        @(negedge clk);
        bus.place_req = 1'b1;
        @(negedge clk);
        bus.place_req = 1'b0;
    endtask

    task automatic run_wait(output int cyc, output int nd, output int nbad);
        bit fin = 0;
        cyc = 0; nd = 0; nbad = 0;
        for (int k = 0; k < 1000; k++) begin
            if (bus.place_done) nd++;
            if (bus.occ_rd_en &&
                (bus.occ_rd_x < 1 || bus.occ_rd_x > 14 ||
                 bus.occ_rd_y < 1 || bus.occ_rd_y > 14))
                nbad++;
            if (!bus.place_busy) begin
                fin = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (!fin) chk("timeout", 0, 1);
    endtask

    int cyc, nd, nbad;

    initial begin
        bus.place_req = 1'b0;
        bus.rand_x = 4'd5;
        bus.rand_y = 4'd9;
        fill(1'b0);
        #2;
        chk("rst_valid", bus.apple_valid, 0);
        chk("rst_busy", bus.place_busy, 0);
        chk("rst_rden", bus.occ_rd_en, 0);
        chk("rst_full", bus.board_full, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // 1: first candidate free
        req();
        chk("t1_busy0", bus.place_busy, 1);
        chk("t1_rden", bus.occ_rd_en, 1);
        @(negedge clk);
        chk("t1_busy1", bus.place_busy, 1);
        chk("t1_done_early", bus.place_done, 0);
        @(negedge clk);
        chk("t1_done", bus.place_done, 1);
        chk("t1_valid", bus.apple_valid, 1);
        chk("t1_busy2", bus.place_busy, 0);
        chk("t1_x", bus.apple_x, 5);
        chk("t1_y", bus.apple_y, 9);
        @(negedge clk);
        chk("t1_pulse", bus.place_done, 0);

        // 2: one retry
        occ[5][9] = 1'b1;
        req();
        bus.rand_x = 4'd3;
        bus.rand_y = 4'd3;
        repeat (2) @(negedge clk);
        chk("t2_valid_mid", bus.apple_valid, 0);
        chk("t2_hold_x", bus.apple_x, 5);
        chk("t2_done_mid", bus.place_done, 0);
        repeat (2) @(negedge clk);
        chk("t2_done", bus.place_done, 1);
        chk("t2_x", bus.apple_x, 3);
        chk("t2_y", bus.apple_y, 3);

        // 3: all random tries occupied, scan finds (2,1)
        bus.rand_x = 4'd5;
        bus.rand_y = 4'd9;
        fill(1'b1);
        occ[2][1] = 1'b0;
        req();
        run_wait(cyc, nd, nbad);
        chk("t3_lat", cyc, 20);
        chk("t3_nd", nd, 1);
        chk("t3_x", bus.apple_x, 2);
        chk("t3_y", bus.apple_y, 1);

        // 4: full board
        fill(1'b1);
        req();
        run_wait(cyc, nd, nbad);
        chk("t4_lat", cyc, 408);
        chk("t4_nd", nd, 0);
        chk("t4_bad", nbad, 0);
        chk("t4_full", bus.board_full, 1);
        chk("t4_valid", bus.apple_valid, 0);
        fill(1'b0);
        req();
        chk("t4_clr", bus.board_full, 0);
        run_wait(cyc, nd, nbad);
        chk("t4b_lat", cyc, 2);
        chk("t4b_x", bus.apple_x, 5);

        // 5: long/repeated req gives one placement
        occ[5][9] = 1'b1;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.place_req = (k < 4) || (k == 8);
            if (bus.place_done) nd++;
        end
        bus.place_req = 1'b0;
        chk("t5_nd", nd, 1);
        chk("t5_busy", bus.place_busy, 0);
        chk("t5_x", bus.apple_x, 1);
        chk("t5_y", bus.apple_y, 1);
        req();
        repeat (17) @(negedge clk);
        chk("t5_inscan", bus.place_busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_valid", bus.apple_valid, 0);
        chk("t5_rst_x", bus.apple_x, 0);
        chk("t5_rst_busy", bus.place_busy, 0);
        chk("t5_rst_rden", bus.occ_rd_en, 0);
        @(negedge clk);
        reset_n = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.place_done) nd++;
        end
        chk("t5_nocommit", nd, 0);
        chk("t5_idle", bus.place_busy, 0);

        // 6: out-of-range random candidate
        fill(1'b0);
        bus.rand_x = 4'd0;
        bus.rand_y = 4'd15;
        req();
        run_wait(cyc, nd, nbad);
        chk("t6_lat", cyc, 18);
        chk("t6_bad", nbad, 8);
        chk("t6_nd", nd, 1);
        chk("t6_x", bus.apple_x, 1);
        chk("t6_y", bus.apple_y, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
